uart_wb_arbiter: RTL and testbench

Two-master Wishbone (classic, single-beat) arbiter sharing the UART register slave between two bus masters. Sits directly in front of the UART's `i_wb_*`/`o_wb_*` port, grants one master at a time with round-robin fairness, and relays data, `ack` and `err` back to the granted master. An optional watchdog converts a hung slave access into a master-side error.

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/uart_arb_rr.sv | 49 ++++
 rtl/uart_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_wb_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and defaults for the two-master Wishbone arbiter that fronts the
// UART register slave.
//   arb_state_t            : arbiter FSM states (IDLE / BUSY / DONE)
//   master_idx_t           : index of a bus master (0 = m0, 1 = m1)
//   ARB_TIMEOUT_CYCLES_DEF : default watchdog length in BUSY cycles
// -----------------------------------------------------------------------------
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef logic master_idx_t;

   localparam int unsigned ARB_TIMEOUT_CYCLES_DEF = 32'd64;

endpackage : uart_arb_pkg

// File: rtl/uart_arb_rr.sv
// -----------------------------------------------------------------------------
// uart_arb_rr
// Combinational two-way round-robin picker. A lone requester always wins; on a
// tie the master that was NOT granted last wins.
// Ports:
//   req      in  2  request vector (bit0 = m0)
//   last_gnt in  1  index of the master granted last
//   gnt      out 2  one-hot pick, 2'b00 when nobody requests
//   gnt_idx  out 1  index of the pick (0 when nobody requests)
// -----------------------------------------------------------------------------
module uart_arb_rr
   import uart_arb_pkg::*;
(
   input  logic [1:0]  req,
   input  master_idx_t last_gnt,
   output logic [1:0]  gnt,
   output master_idx_t gnt_idx
);

   // Pick the winner from the current request vector and grant history
   always_comb begin
      gnt     = 2'b00;
      gnt_idx = 1'b0;
      case (req)
         2'b01: begin
            gnt     = 2'b01;
            gnt_idx = 1'b0;
         end
         2'b10: begin
            gnt     = 2'b10;
            gnt_idx = 1'b1;
         end
         2'b11: begin
            if (last_gnt == 1'b1) begin
               gnt     = 2'b01;
               gnt_idx = 1'b0;
            end else begin
               gnt     = 2'b10;
               gnt_idx = 1'b1;
            end
         end
         default: begin
            gnt     = 2'b00;
            gnt_idx = 1'b0;
         end
      endcase
   end

endmodule : uart_arb_rr

// File: rtl/uart_wb_arbiter.sv
// -----------------------------------------------------------------------------
// uart_wb_arbiter
// Two-master classic Wishbone arbiter in front of the UART register slave.
// One single-beat access at a time, round-robin on ties, response (data, ack,
// err) relayed only to the granted master. Every output is a flop.
//
// Optional build macro: UART_ARB_TIMEOUT_EN
//   defined   -> a watchdog aborts a BUSY access after TIMEOUT_CYCLES cycles
//                without slave ack/err and returns err to the master.
//   undefined -> no watchdog; BUSY waits for the slave indefinitely.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), async active-high reset
//   i_mN_adr/we/dat/stb          master N request (N = 0, 1)
//   o_mN_dat/ack/err             master N response; ack/err are 1-cycle pulses
//   o_wb_adr/we/dat/stb          registered request to the UART slave
//   i_wb_dat/ack/err             slave response
//   o_gnt                        one-hot grant (bit0 = m0), 0 when idle
// -----------------------------------------------------------------------------
module uart_wb_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_m0_adr,
   input  logic        i_m0_we,
   input  logic [31:0] i_m0_dat,
   input  logic        i_m0_stb,
   input  logic [31:0] i_m1_adr,
   input  logic        i_m1_we,
   input  logic [31:0] i_m1_dat,
   input  logic        i_m1_stb,
   output logic [31:0] o_m0_dat,
   output logic        o_m0_ack,
   output logic        o_m0_err,
   output logic [31:0] o_m1_dat,
   output logic        o_m1_ack,
   output logic        o_m1_err,
   output logic [31:0] o_wb_adr,
   output logic        o_wb_we,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_stb,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_ack,
   input  logic        i_wb_err,
   output logic [1:0]  o_gnt
);

   if ((TIMEOUT_CYCLES < 32'd2) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
      $error("uart_wb_arbiter: TIMEOUT_CYCLES must be within 2..65535");
   end

   arb_state_t  state_r, state_nxt_s;
   master_idx_t last_gnt_r, last_gnt_nxt_s;
   master_idx_t gnt_idx_r, gnt_idx_nxt_s;
   logic [1:0]  gnt_r, gnt_nxt_s;

   logic [31:0] wb_adr_r, wb_adr_nxt_s;
   logic [31:0] wb_dat_r, wb_dat_nxt_s;
   logic        wb_we_r, wb_we_nxt_s;
   logic        wb_stb_r, wb_stb_nxt_s;

   logic [31:0] m0_dat_r, m0_dat_nxt_s;
   logic [31:0] m1_dat_r, m1_dat_nxt_s;
   logic        m0_ack_r, m0_ack_nxt_s;
   logic        m1_ack_r, m1_ack_nxt_s;
   logic        m0_err_r, m0_err_nxt_s;
   logic        m1_err_r, m1_err_nxt_s;

   logic [1:0]  req_s;
   logic [1:0]  pick_gnt_s;
   master_idx_t pick_idx_s;
   logic        ack_win_s;
   logic        tmo_hit_s;

   assign req_s = {i_m1_stb, i_m0_stb};

   // A clean ack only when err is absent: err always dominates ack. Anything
   // else that ends BUSY (err or watchdog) is reported as err.
   assign ack_win_s = i_wb_ack & ~i_wb_err;

   uart_arb_rr u_rr (
      .req      (req_s),
      .last_gnt (last_gnt_r),
      .gnt      (pick_gnt_s),
      .gnt_idx  (pick_idx_s)
   );

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 32'd1);

   logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_nxt_s;

   // Expiry in the cycle the count shows TIMEOUT_CYCLES-1; an ack seen in the
   // same cycle takes priority in the FSM because ack/err are tested first.
   assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 32'd1));

   // Watchdog next count: held at zero outside BUSY so it starts clean on entry
   always_comb begin
      tmo_cnt_nxt_s = tmo_cnt_r;
      if (state_r == BUSY) begin
         tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
      end else begin
         tmo_cnt_nxt_s = {TMO_W{1'b0}};
      end
   end

   // Watchdog counter register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_nxt_s;
      end
   end
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Next-state and next-output decode for the arbiter FSM
   always_comb begin
      state_nxt_s    = state_r;
      last_gnt_nxt_s = last_gnt_r;
      gnt_idx_nxt_s  = gnt_idx_r;
      gnt_nxt_s      = gnt_r;
      wb_adr_nxt_s   = wb_adr_r;
      wb_dat_nxt_s   = wb_dat_r;
      wb_we_nxt_s    = wb_we_r;
      wb_stb_nxt_s   = wb_stb_r;
      m0_dat_nxt_s   = m0_dat_r;
      m1_dat_nxt_s   = m1_dat_r;
      m0_ack_nxt_s   = 1'b0;
      m1_ack_nxt_s   = 1'b0;
      m0_err_nxt_s   = 1'b0;
      m1_err_nxt_s   = 1'b0;

      case (state_r)
         IDLE: begin
            if (req_s != 2'b00) begin
               gnt_idx_nxt_s = pick_idx_s;
               gnt_nxt_s     = pick_gnt_s;
               wb_stb_nxt_s  = 1'b1;
               state_nxt_s   = BUSY;
               if (pick_idx_s == 1'b0) begin
                  wb_adr_nxt_s = i_m0_adr;
                  wb_we_nxt_s  = i_m0_we;
                  wb_dat_nxt_s = i_m0_dat;
               end else begin
                  wb_adr_nxt_s = i_m1_adr;
                  wb_we_nxt_s  = i_m1_we;
                  wb_dat_nxt_s = i_m1_dat;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end

         BUSY: begin
            // Master stb is deliberately not looked at here: once issued, the
            // slave access always runs to completion.
            if (i_wb_ack || i_wb_err || tmo_hit_s) begin
               wb_stb_nxt_s = 1'b0;
               state_nxt_s  = DONE;
               if (gnt_idx_r == 1'b0) begin
                  m0_ack_nxt_s = ack_win_s;
                  m0_err_nxt_s = ~ack_win_s;
                  if (ack_win_s) begin
                     m0_dat_nxt_s = i_wb_dat;
                  end else begin
                     m0_dat_nxt_s = m0_dat_r;
                  end
               end else begin
                  m1_ack_nxt_s = ack_win_s;
                  m1_err_nxt_s = ~ack_win_s;
                  if (ack_win_s) begin
                     m1_dat_nxt_s = i_wb_dat;
                  end else begin
                     m1_dat_nxt_s = m1_dat_r;
                  end
               end
            end else begin
               state_nxt_s = BUSY;
            end
         end

         DONE: begin
            last_gnt_nxt_s = gnt_idx_r;
            gnt_nxt_s      = 2'b00;
            state_nxt_s    = IDLE;
         end

         default: begin
            state_nxt_s  = IDLE;
            wb_stb_nxt_s = 1'b0;
            gnt_nxt_s    = 2'b00;
         end
      endcase
   end

   // FSM state and grant history registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r    <= IDLE;
         last_gnt_r <= 1'b1;
         gnt_idx_r  <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         last_gnt_r <= last_gnt_nxt_s;
         gnt_idx_r  <= gnt_idx_nxt_s;
      end
   end

   // Registered bus-side and master-side outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         gnt_r    <= 2'b00;
         wb_adr_r <= 32'h0000_0000;
         wb_dat_r <= 32'h0000_0000;
         wb_we_r  <= 1'b0;
         wb_stb_r <= 1'b0;
         m0_dat_r <= 32'h0000_0000;
         m1_dat_r <= 32'h0000_0000;
         m0_ack_r <= 1'b0;
         m1_ack_r <= 1'b0;
         m0_err_r <= 1'b0;
         m1_err_r <= 1'b0;
      end else begin
         gnt_r    <= gnt_nxt_s;
         wb_adr_r <= wb_adr_nxt_s;
         wb_dat_r <= wb_dat_nxt_s;
         wb_we_r  <= wb_we_nxt_s;
         wb_stb_r <= wb_stb_nxt_s;
         m0_dat_r <= m0_dat_nxt_s;
         m1_dat_r <= m1_dat_nxt_s;
         m0_ack_r <= m0_ack_nxt_s;
         m1_ack_r <= m1_ack_nxt_s;
         m0_err_r <= m0_err_nxt_s;
         m1_err_r <= m1_err_nxt_s;
      end
   end

   assign o_gnt    = gnt_r;
   assign o_wb_adr = wb_adr_r;
   assign o_wb_dat = wb_dat_r;
   assign o_wb_we  = wb_we_r;
   assign o_wb_stb = wb_stb_r;
   assign o_m0_dat = m0_dat_r;
   assign o_m1_dat = m1_dat_r;
   assign o_m0_ack = m0_ack_r;
   assign o_m1_ack = m1_ack_r;
   assign o_m0_err = m0_err_r;
   assign o_m1_err = m1_err_r;

endmodule : uart_wb_arbiter

// File: tb/tb_uart_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_wb_arbiter
// Directed scenarios for the arbiter's key behaviours, followed by a random
// phase checked against a transaction-timing reference model. Inputs are
// driven 1 time unit after each rising edge and outputs sampled at the same
// point, so "cycle n" means the interval after rising edge n.
// -----------------------------------------------------------------------------
module tb_uart_wb_arbiter;

   localparam int unsigned TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] madr  [2];
   logic [31:0] mwdat [2];
   logic        mwe   [2];
   logic        mstb  [2];
   logic [31:0] mrdat [2];
   logic        mack  [2];
   logic        merr  [2];
   logic [31:0] wb_adr, wb_wdat, wb_rdat;
   logic        wb_we, wb_stb, wb_ack, wb_err;
   logic [1:0]  gnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference-model state for the random phase
   int          cur_m, last_m, start_c, resp_at, free_at, kind;
   bit          busy, dropped, r_err, r_ackin, cont, resp_now;
   bit          pend [2];
   logic [31:0] exp_rd [2];
   logic [31:0] ex_adr, ex_dat, r_dat;
   logic        ex_we;

   uart_wb_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_m0_adr (madr[0]),
      .i_m0_we  (mwe[0]),
      .i_m0_dat (mwdat[0]),
      .i_m0_stb (mstb[0]),
      .i_m1_adr (madr[1]),
      .i_m1_we  (mwe[1]),
      .i_m1_dat (mwdat[1]),
      .i_m1_stb (mstb[1]),
      .o_m0_dat (mrdat[0]),
      .o_m0_ack (mack[0]),
      .o_m0_err (merr[0]),
      .o_m1_dat (mrdat[1]),
      .o_m1_ack (mack[1]),
      .o_m1_err (merr[1]),
      .o_wb_adr (wb_adr),
      .o_wb_we  (wb_we),
      .o_wb_dat (wb_wdat),
      .o_wb_stb (wb_stb),
      .i_wb_dat (wb_rdat),
      .i_wb_ack (wb_ack),
      .i_wb_err (wb_err),
      .o_gnt    (gnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] onehot(input int m);
      return (m == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic quiet_inputs();
      for (int m = 0; m < 2; m++) begin
         madr[m]  = 32'h0;
         mwdat[m] = 32'h0;
         mwe[m]   = 1'b0;
         mstb[m]  = 1'b0;
      end
      wb_ack  = 1'b0;
      wb_err  = 1'b0;
      wb_rdat = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      quiet_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_stb"},  {31'h0, wb_stb},   32'h0);
      check_eq({pfx, "_gnt"},  {30'h0, gnt},      32'h0);
      check_eq({pfx, "_adr"},  wb_adr,            32'h0);
      check_eq({pfx, "_we"},   {31'h0, wb_we},    32'h0);
      check_eq({pfx, "_wdat"}, wb_wdat,           32'h0);
      check_eq({pfx, "_m0d"},  mrdat[0],          32'h0);
      check_eq({pfx, "_m1d"},  mrdat[1],          32'h0);
      check_eq({pfx, "_rsp"},  {28'h0, mack[0], mack[1], merr[0], merr[1]}, 32'h0);
   endtask

   // global time limit so the run can never hang
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      quiet_inputs();

      // ---- reset values, then m0 write acked 2 cycles after stb ----
      do_reset();
      check_all_zero("rst");
      madr[0] = 32'h0000_0004; mwdat[0] = 32'h0000_00A5; mwe[0] = 1'b1; mstb[0] = 1'b1;
      tick();                                         // cycle 1
      check_eq("wr_stb",  {31'h0, wb_stb}, 32'h1);
      check_eq("wr_gnt",  {30'h0, gnt},    32'h1);
      check_eq("wr_adr",  wb_adr,          32'h0000_0004);
      check_eq("wr_dat",  wb_wdat,         32'h0000_00A5);
      check_eq("wr_we",   {31'h0, wb_we},  32'h1);
      tick();                                         // cycle 2
      check_eq("wr_ack_c2", {31'h0, mack[0]}, 32'h0);
      tick();                                         // cycle 3: slave acks
      check_eq("wr_ack_c3", {31'h0, mack[0]}, 32'h0);
      wb_ack = 1'b1; wb_rdat = 32'hCAFE_0001;
      tick();                                         // cycle 4
      check_eq("wr_ack_c4",  {31'h0, mack[0]}, 32'h1);
      check_eq("wr_m1ack",   {31'h0, mack[1]}, 32'h0);
      check_eq("wr_stb_c4",  {31'h0, wb_stb},  32'h0);
      wb_ack = 1'b0; mstb[0] = 1'b0;
      tick();                                         // cycle 5
      check_eq("wr_ack_c5",  {31'h0, mack[0]}, 32'h0);

      // ---- m1 read returning DEADBEEF ----
      madr[1] = 32'h0000_0008; mwe[1] = 1'b0; mstb[1] = 1'b1;
      tick();
      check_eq("rd_gnt",  {30'h0, gnt},    32'h2);
      check_eq("rd_adr",  wb_adr,          32'h0000_0008);
      check_eq("rd_we",   {31'h0, wb_we},  32'h0);
      wb_ack = 1'b1; wb_rdat = 32'hDEAD_BEEF;
      tick();
      check_eq("rd_ack",  {31'h0, mack[1]}, 32'h1);
      check_eq("rd_dat",  mrdat[1],         32'hDEAD_BEEF);
      check_eq("rd_m0ack",{31'h0, mack[0]}, 32'h0);
      check_eq("rd_m0dat",mrdat[0],         32'hCAFE_0001);
      wb_ack = 1'b0; mstb[1] = 1'b0; wb_rdat = 32'h0;
      tick();
      check_eq("rd_ack_off", {31'h0, mack[1]}, 32'h0);

      // ---- slave err, then ack+err together: err only, data held ----
      for (int t = 0; t < 2; t++) begin
         madr[0] = 32'h0000_000C; mstb[0] = 1'b1;
         tick();
         check_eq("er_stb", {31'h0, wb_stb}, 32'h1);
         wb_err = 1'b1; wb_ack = (t == 1); wb_rdat = 32'h1111_2222;
         tick();
         check_eq($sformatf("er%0d_err", t), {31'h0, merr[0]}, 32'h1);
         check_eq($sformatf("er%0d_ack", t), {31'h0, mack[0]}, 32'h0);
         check_eq($sformatf("er%0d_dat", t), mrdat[0],         32'hCAFE_0001);
         wb_err = 1'b0; wb_ack = 1'b0; mstb[0] = 1'b0;
         tick();
         check_eq($sformatf("er%0d_off", t), {31'h0, merr[0]}, 32'h0);
      end

`ifdef UART_ARB_TIMEOUT_EN
      // ---- watchdog: no response, then ack on the last allowed cycle ----
      for (int t = 0; t < 2; t++) begin
         madr[0] = 32'h0000_0010; mstb[0] = 1'b1;
         for (int b = 1; b <= 8; b++) begin
            tick();
            check_eq($sformatf("to%0d_stb_b%0d", t, b), {31'h0, wb_stb}, 32'h1);
            if (b == 8 && t == 1) begin
               wb_ack = 1'b1;
            end
         end
         tick();
         check_eq($sformatf("to%0d_stb_end", t), {31'h0, wb_stb},  32'h0);
         check_eq($sformatf("to%0d_err", t),     {31'h0, merr[0]}, (t == 0) ? 32'h1 : 32'h0);
         check_eq($sformatf("to%0d_ack", t),     {31'h0, mack[0]}, (t == 0) ? 32'h0 : 32'h1);
         wb_ack = 1'b0; mstb[0] = 1'b0;
         tick();
      end
`endif

      // ---- async reset mid-BUSY, then tie after reset goes to m0 ----
      madr[1] = 32'h0000_0014; mwdat[1] = 32'h5A5A_0000; mwe[1] = 1'b1; mstb[1] = 1'b1;
      tick();
      check_eq("mr_gnt", {30'h0, gnt}, 32'h2);
      #2 rst = 1'b1;
      #1;
      check_all_zero("mr");
      quiet_inputs();
      @(posedge clk);
      #1 rst = 1'b0;
      cyc = 0;
      mstb[0] = 1'b1; mstb[1] = 1'b1;
      tick();
      check_eq("mr_tie_gnt", {30'h0, gnt}, 32'h1);
      wb_ack = 1'b1;
      tick();
      check_eq("mr_tie_ack", {31'h0, mack[0]}, 32'h1);
      wb_ack = 1'b0;

      // ---- random phase against the reference model ----
      do_reset();
      last_m  = 1;
      busy    = 1'b0;
      dropped = 1'b0;
      free_at = 0;
      cur_m   = 0;
      start_c = 0;
      resp_at = 0;
      for (int m = 0; m < 2; m++) begin
         pend[m]   = 1'b0;
         exp_rd[m] = 32'h0;
      end
      for (int n = 0; n < 2500; n++) begin
         cont = (n < 300);
         // masters: raise new requests, the granted one may drop stb early
         for (int m = 0; m < 2; m++) begin
            if (!pend[m] && (cont || $urandom_range(0, 2) == 0)) begin
               pend[m]  = 1'b1;
               madr[m]  = $urandom;
               mwdat[m] = $urandom;
               mwe[m]   = 1'($urandom_range(0, 1));
            end
            if (busy && m == cur_m && cyc >= start_c && !cont && !dropped &&
                $urandom_range(0, 7) == 0) begin
               dropped = 1'b1;
            end
            mstb[m] = pend[m] && !(dropped && m == cur_m);
         end
         // model: the arbiter samples requests whenever it is free
         if (!busy && cyc >= free_at && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) cur_m = 1 - last_m;
            else if (pend[0])       cur_m = 0;
            else                    cur_m = 1;
            ex_adr  = madr[cur_m];
            ex_dat  = mwdat[cur_m];
            ex_we   = mwe[cur_m];
            busy    = 1'b1;
            start_c = cyc + 1;
            resp_at = start_c + $urandom_range(0, 4);
            kind    = $urandom_range(0, 7);
            r_err   = (kind < 2);
            r_ackin = (kind != 0);
            r_dat   = $urandom;
         end
         // slave: answer in the chosen cycle, junk data otherwise
         wb_ack  = 1'b0;
         wb_err  = 1'b0;
         wb_rdat = $urandom;
         if (busy && cyc == resp_at) begin
            wb_ack  = r_ackin;
            wb_err  = r_err;
            wb_rdat = r_dat;
         end
         tick();
         resp_now = busy && (cyc == resp_at + 1);
         if (busy && cyc >= start_c && cyc <= resp_at) begin
            check_eq($sformatf("r_stb@%0d", cyc), {31'h0, wb_stb}, 32'h1);
            check_eq($sformatf("r_gnt@%0d", cyc), {30'h0, gnt},    {30'h0, onehot(cur_m)});
            check_eq($sformatf("r_adr@%0d", cyc), wb_adr,          ex_adr);
            check_eq($sformatf("r_wd@%0d", cyc),  wb_wdat,         ex_dat);
            check_eq($sformatf("r_we@%0d", cyc),  {31'h0, wb_we},  {31'h0, ex_we});
         end else begin
            check_eq($sformatf("r_stb@%0d", cyc), {31'h0, wb_stb}, 32'h0);
            if (!resp_now) begin
               check_eq($sformatf("r_gnt@%0d", cyc), {30'h0, gnt}, 32'h0);
            end
         end
         if (resp_now && !r_err) exp_rd[cur_m] = r_dat;
         for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("r_ack%0d@%0d", m, cyc), {31'h0, mack[m]},
                     {31'h0, (resp_now && m == cur_m && !r_err)});
            check_eq($sformatf("r_err%0d@%0d", m, cyc), {31'h0, merr[m]},
                     {31'h0, (resp_now && m == cur_m && r_err)});
            check_eq($sformatf("r_rd%0d@%0d", m, cyc), mrdat[m], exp_rd[m]);
         end
         if (resp_now) begin
            pend[cur_m] = 1'b0;
            dropped     = 1'b0;
            busy        = 1'b0;
            free_at     = cyc + 1;
            last_m      = cur_m;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uart_wb_arbiter
